// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared definitions for the MIPS32 multiply/divide unit:
//               op encodings, control FSM states, counter sizing and the
//               conditional two's-complement negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // MULT/MULTU/DIV/DIVU encodings; op[0]==0 selects the signed flavour
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Widest operand the negate helper handles; products need twice that
  localparam int MAX_WIDTH = 64;
  localparam int NEG_W     = 2 * MAX_WIDTH;

  // Iteration counter width: enough bits to count 0..width-1
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Counter width for the default 32-bit datapath
  localparam int CNT_W = cnt_width(32);

  // Negate x when neg is set. Callers zero-extend narrower values into the
  // NEG_W-bit argument and truncate the result; the low bits of a wide
  // two's-complement negate equal the narrow negate, so this is exact.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x,
                                                 input logic             neg);
    return neg ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative multiply/divide unit with HI/LO registers.
//               Shift-add multiply and restoring divide, one bit per cycle,
//               operating on magnitudes with a final sign-fix cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [2*WIDTH-1:0]     r_acc;      // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]       r_b_mag;    // addend (mult) or divisor (div) magnitude
  logic                   r_is_div;
  logic                   r_neg_res;  // product/quotient must be negated at FIX
  logic                   r_sign_a;   // remainder follows the dividend sign
  logic                   r_b_zero;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_dbz;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t                 w_state_nxt;
  logic                   w_launch;
  logic                   w_step;
  logic                   w_finish;
  logic                   w_mt_ok;

  logic                   w_a_sign;
  logic                   w_b_sign;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;

  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH-1:0]     w_mul_nxt;
  logic [WIDTH:0]         w_shift;
  logic [WIDTH+1:0]       w_diff;
  logic                   w_borrow;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [2*WIDTH-1:0]     w_div_nxt;

  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic                   w_unused;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: launch on start, leave CALC after the last bit, FIX is one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == c_cnt_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    w_launch = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_mt_ok  = 1'b0;
    case (r_state)
      IDLE: begin
        w_launch = start;
        w_mt_ok  = 1'b1;
      end
      CALC:    w_step   = 1'b1;
      FIX:     w_finish = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Operand magnitudes; sign bits count only for the signed ops
  always_comb begin
    w_a_sign = ~op[0] & a[WIDTH-1];
    w_b_sign = ~op[0] & b[WIDTH-1];
    w_a_mag  = WIDTH'(cond_neg(NEG_W'(a), w_a_sign));
    w_b_mag  = WIDTH'(cond_neg(NEG_W'(b), w_b_sign));
  end

  // One multiply bit: add the addend into the upper half if the multiplier
  // LSB is set, then shift the whole accumulator right (carry enters the MSB)
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                (r_acc[0] ? {1'b0, r_b_mag} : {(WIDTH+1){1'b0}});
    w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};
  end

  // One restoring-divide bit: shift the next dividend bit into the remainder,
  // keep the difference if it did not borrow, and record the quotient bit
  always_comb begin
    w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_b_mag};
    w_borrow  = w_diff[WIDTH+1];
    w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], ~w_borrow};
  end

  // When no borrow occurs the difference is below the divisor, so bit WIDTH
  // of w_diff is always zero and never needed
  assign w_unused = &{1'b0, w_diff[WIDTH]};

  // Sign-corrected results applied at FIX
  always_comb begin
    w_prod = (2*WIDTH)'(cond_neg(NEG_W'(r_acc), r_neg_res));
    w_quo  = WIDTH'(cond_neg(NEG_W'(r_acc[WIDTH-1:0]), r_neg_res));
    w_rem  = WIDTH'(cond_neg(NEG_W'(r_acc[2*WIDTH-1:WIDTH]), r_sign_a));
  end

  // Operand latch at launch and one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b_mag   <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_sign_a  <= 1'b0;
      r_b_zero  <= 1'b0;
    end else if (w_launch) begin
      r_cnt     <= '0;
      r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
      r_b_mag   <= w_b_mag;
      r_is_div  <= op[1];
      r_neg_res <= w_a_sign ^ w_b_sign;
      r_sign_a  <= w_a_sign;
      r_b_zero  <= (b == '0);
    end else if (w_step) begin
      r_cnt     <= r_cnt + c_cnt_w'(1);
      r_acc     <= r_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

  // HI/LO: operation result at FIX, otherwise MTHI/MTLO while idle.
  // A zero divisor naturally leaves |a| as remainder, which the sign fix
  // turns back into a; only the quotient needs forcing to all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= r_b_zero ? {WIDTH{1'b1}} : w_quo;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (w_mt_ok) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  // Registered status: busy spans launch..FIX, done/div_by_zero pulse after FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      r_done <= w_finish;
      r_dbz  <= w_finish & r_is_div & r_b_zero;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam logic [1:0] T_MULT  = 2'b00;
  localparam logic [1:0] T_MULTU = 2'b01;
  localparam logic [1:0] T_DIV   = 2'b10;
  localparam logic [1:0] T_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Launch one op and wait (bounded) for done. lat counts rising edges after
  // the launch edge until done is seen; bcnt counts sampled busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt, output logic dz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL reset_hi got %h want 0", hi); end
    total++; if (lo !== 32'h0)         begin bad++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int lat, bcnt; logic dz;
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, dz);
    total++; if (lat !== 33)           begin bad++; $display("FAIL multu_latency got %0d want 33", lat); end
    total++; if (bcnt !== 33)          begin bad++; $display("FAIL multu_busy_cycles got %0d want 33", bcnt); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL multu_dbz got %b want 0", dz); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult_signed();
    int lat, bcnt; logic dz;
    run_op(T_MULT, 32'hFFFF_FFFD, 32'd7, lat, bcnt, dz);
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo); end
    run_op(T_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFC, lat, bcnt, dz);
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL mult_negneg_hi got %h want 0", hi); end
    total++; if (lo !== 32'd20)        begin bad++; $display("FAIL mult_negneg_lo got %h want 14", lo); end
  endtask

  task automatic test_div_signed();
    int lat, bcnt; logic dz;
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt, dz);
    total++; if (lat !== 33)           begin bad++; $display("FAIL div_latency got %0d want 33", lat); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    run_op(T_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt, dz);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negdiv_lo got %h want fffffffd", lo); end
    total++; if (hi !== 32'h1)         begin bad++; $display("FAIL div_negdiv_hi got %h want 1", hi); end
    run_op(T_DIVU, 32'hFFFF_FFF9, 32'd2, lat, bcnt, dz);
    total++; if (lo !== 32'h7FFF_FFFC) begin bad++; $display("FAIL divu_big_lo got %h want 7ffffffc", lo); end
    total++; if (hi !== 32'h1)         begin bad++; $display("FAIL divu_big_hi got %h want 1", hi); end
  endtask

  task automatic test_div_by_zero();
    int lat, bcnt; logic dz;
    run_op(T_DIVU, 32'd100, 32'd0, lat, bcnt, dz);
    total++; if (lat !== 33)           begin bad++; $display("FAIL dbz_latency got %0d want 33", lat); end
    total++; if (dz !== 1'b1)          begin bad++; $display("FAIL dbz_flag got %b want 1", dz); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
    total++; if (hi !== 32'd100)       begin bad++; $display("FAIL dbz_hi got %h want 64", hi); end
    @(negedge clk);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_pulse got %b want 0", div_by_zero); end
    run_op(T_DIV, 32'hFFFF_FF9C, 32'd0, lat, bcnt, dz);
    total++; if (dz !== 1'b1)          begin bad++; $display("FAIL sdbz_flag got %b want 1", dz); end
    total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sdbz_lo got %h want ffffffff", lo); end
    total++; if (hi !== 32'hFFFF_FF9C) begin bad++; $display("FAIL sdbz_hi got %h want ffffff9c", hi); end
  endtask

  task automatic test_div_overflow();
    int lat, bcnt; logic dz;
    run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, dz);
    total++; if (dz !== 1'b0)          begin bad++; $display("FAIL ovf_flag got %b want 0", dz); end
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got %h want 80000000", lo); end
    total++; if (hi !== 32'h0)         begin bad++; $display("FAIL ovf_hi got %h want 0", hi); end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    logic [31:0] got_hi = '0;
    logic [31:0] got_lo = '0;
    @(negedge clk);
    start = 1'b1; op = T_DIVU; a = 32'd50; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 5) begin
        start = 1'b1; op = T_MULTU; a = 32'd1000; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        dones++;
        got_hi = hi;
        got_lo = lo;
      end
    end
    start = 1'b0;
    total++; if (dones !== 1)      begin bad++; $display("FAIL busy_start_dones got %0d want 1", dones); end
    total++; if (got_lo !== 32'd7) begin bad++; $display("FAIL busy_start_lo got %h want 7", got_lo); end
    total++; if (got_hi !== 32'd1) begin bad++; $display("FAIL busy_start_hi got %h want 1", got_hi); end
  endtask

  task automatic test_mt_writes();
    int lat, bcnt; logic dz;
    // preload both in idle
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h99;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    total++; if (hi !== 32'h99) begin bad++; $display("FAIL mt_preload_hi got %h want 99", hi); end
    // MTHI while busy is dropped
    start = 1'b1; op = T_MULTU; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    total++; if (hi !== 32'h99) begin bad++; $display("FAIL mt_busy_hi got %h want 99", hi); end
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL mt_after_fix_hi got %h want 0", hi); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL mt_after_fix_lo got %h want 2a", lo); end
    // both writes together in idle
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    total++; if (hi !== 32'hABCD) begin bad++; $display("FAIL mt_both_hi got %h want abcd", hi); end
    total++; if (lo !== 32'hABCD) begin bad++; $display("FAIL mt_both_lo got %h want abcd", lo); end
    // same-edge write and launch: write lands, result later overwrites
    start = 1'b1; op = T_MULTU; a = 32'd2; b = 32'd2; hi_we = 1'b1; wdata = 32'h77;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    total++; if (hi !== 32'h77)  begin bad++; $display("FAIL mt_same_edge_hi got %h want 77", hi); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL mt_same_edge_busy got %b want 1", busy); end
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    total++; if (lat !== 33)     begin bad++; $display("FAIL mt_same_edge_latency got %0d want 33", lat); end
    total++; if (hi !== 32'h0)   begin bad++; $display("FAIL mt_same_edge_res_hi got %h want 0", hi); end
    total++; if (lo !== 32'd4)   begin bad++; $display("FAIL mt_same_edge_res_lo got %h want 4", lo); end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt; logic dz;
    int dones = 0;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    start = 1'b1; op = T_MULTU; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL abort_hi got %h want 0", hi); end
    total++; if (lo !== 32'h0)  begin bad++; $display("FAIL abort_lo got %h want 0", lo); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones !== 0)   begin bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
    total++; if (lo !== 32'h0)  begin bad++; $display("FAIL abort_lo_stays got %h want 0", lo); end
    run_op(T_MULT, 32'd2, 32'd3, lat, bcnt, dz);
    total++; if (lat !== 33)    begin bad++; $display("FAIL abort_next_latency got %0d want 33", lat); end
    total++; if (lo !== 32'd6)  begin bad++; $display("FAIL abort_next_lo got %h want 6", lo); end
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL abort_next_hi got %h want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div_signed();
    test_div_by_zero();
    test_div_overflow();
    test_start_while_busy();
    test_mt_writes();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
